// File: rtl/regfile_sched_pkg.sv
// Shared types and defaults for the register-file write scheduler.
package regfile_sched_pkg;

  localparam int WORD_LEN   = 32;
  localparam int WORD_COUNT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } schedState_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } reqId_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; rrPtr remembers the last served requester.
module rr_arbiter2
  import regfile_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       advance,
  output logic [1:0] gnt
);

  reqId_t rrPtr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // on a tie, serve whoever was not served last
        2'b11:   gnt = (rrPtr == REQ0) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rrPtr <= REQ0;
    end else if (advance) begin
      rrPtr <= gnt[1] ? REQ1 : REQ0;
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port between two writeback requesters and
// sequences a full-file clear sweep.
//   state | meaning
//   IDLE  | arbitrate r0/r1 requests
//   SWEEP | issue one sclr per register, index 0..WordCount-1
//   DONE  | one-cycle completion pulse, then IDLE
module regfile_write_scheduler
  import regfile_sched_pkg::*;
#(
  parameter  int WordLen   = WORD_LEN,
  parameter  int WordCount = WORD_COUNT,
  localparam int Bits      = $clog2(WordCount)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r0_valid,
  output logic               r0_ready,
  input  logic [Bits-1:0]    r0_addr,
  input  logic [WordLen-1:0] r0_data,
  input  logic               r0_clr,
  input  logic               r1_valid,
  output logic               r1_ready,
  input  logic [Bits-1:0]    r1_addr,
  input  logic [WordLen-1:0] r1_data,
  input  logic               r1_clr,
  input  logic               sweep_start,
  output logic               sweep_busy,
  output logic               sweep_done,
  output logic               addr_err,
  output logic [Bits-1:0]    rf_write_reg,
  output logic [WordLen-1:0] rf_write_data,
  output logic               rf_reg_write,
  output logic               rf_sclr
);

  localparam logic [Bits-1:0] LastIdx = Bits'(WordCount - 1);

  schedState_t state, nextState;
  logic [Bits-1:0] sweepIdx, nextIdx;
  logic [1:0] gnt;
  logic arbEn, accept, selClr, addrOk;
  logic [Bits-1:0] selAddr;
  logic [WordLen-1:0] selData;

  assign arbEn = (state == IDLE) && !sweep_start;

  rr_arbiter2 uArb (
    .clk    (clk),
    .rst    (rst),
    .req    ({r1_valid, r0_valid}),
    .en     (arbEn),
    .advance(accept),
    .gnt    (gnt)
  );

  assign r0_ready = gnt[0];
  assign r1_ready = gnt[1];
  assign accept   = |gnt;
  assign selAddr  = gnt[1] ? r1_addr : r0_addr;
  assign selData  = gnt[1] ? r1_data : r0_data;
  assign selClr   = gnt[1] ? r1_clr  : r0_clr;
  assign addrOk   = 32'(selAddr) < WordCount;

  assign sweep_busy = (state == SWEEP);
  assign sweep_done = (state == DONE);

  always_comb begin
    nextState = state;
    nextIdx   = sweepIdx;
    case (state)
      IDLE: begin
        if (sweep_start) begin
          nextState = SWEEP;
          nextIdx   = '0;
        end
      end
      SWEEP: begin
        if (sweepIdx == LastIdx) nextState = DONE;
        else nextIdx = sweepIdx + Bits'(1);
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sweepIdx <= '0;
    end else begin
      state    <= nextState;
      sweepIdx <= nextIdx;
    end
  end

  // Strobes are registered so the file sees them stable at its negedge capture;
  // the clear for a sweep index lands in the same cycle that index is current.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      rf_reg_write  <= 1'b0;
      rf_sclr       <= 1'b0;
      addr_err      <= 1'b0;
    end else begin
      rf_reg_write <= 1'b0;
      rf_sclr      <= 1'b0;
      addr_err     <= 1'b0;
      if (nextState == SWEEP) begin
        rf_sclr       <= 1'b1;
        rf_write_reg  <= nextIdx;
        rf_write_data <= '0;
      end else if (accept) begin
        if (!addrOk) begin
          addr_err <= 1'b1;
        end else begin
          rf_write_reg  <= selAddr;
          rf_sclr       <= selClr;
          rf_reg_write  <= !selClr;
          rf_write_data <= selClr ? '0 : selData;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for the register-file write scheduler.
module tb_regfile_write_scheduler;

  logic        clk;
  logic        rst;
  logic        r0_valid, r0_ready, r0_clr;
  logic [3:0]  r0_addr;
  logic [31:0] r0_data;
  logic        r1_valid, r1_ready, r1_clr;
  logic [3:0]  r1_addr;
  logic [31:0] r1_data;
  logic        sweep_start, sweep_busy, sweep_done, addr_err;
  logic [3:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rf_reg_write, rf_sclr;

  int nVec = 0;
  int nMis = 0;
  logic [31:0] tbRf [15];

  regfile_write_scheduler dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_data(r0_data), .r0_clr(r0_clr),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_data(r1_data), .r1_clr(r1_clr),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done), .addr_err(addr_err),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .rf_reg_write(rf_reg_write), .rf_sclr(rf_sclr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file model capturing on negedge
  always @(negedge clk) begin
    if (rst && rf_write_reg < 4'd15) begin
      if (rf_sclr) tbRf[rf_write_reg] <= 32'd0;
      else if (rf_reg_write) tbRf[rf_write_reg] <= rf_write_data;
    end
  end

  typedef struct packed {
    logic r0v; logic [3:0] r0a; logic [31:0] r0d; logic r0c;
    logic r1v; logic [3:0] r1a; logic [31:0] r1d; logic r1c;
    logic eR0; logic eR1; logic eWr; logic eClr;
    logic [3:0] eReg; logic [31:0] eData; logic eErr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chkRfIdle(input string name);
    chk({name, " rf_reg_write"}, 32'(rf_reg_write), 32'd0);
    chk({name, " rf_sclr"}, 32'(rf_sclr), 32'd0);
    chk({name, " rf_write_reg"}, 32'(rf_write_reg), 32'd0);
    chk({name, " rf_write_data"}, rf_write_data, 32'd0);
    chk({name, " sweep_busy"}, 32'(sweep_busy), 32'd0);
    chk({name, " sweep_done"}, 32'(sweep_done), 32'd0);
    chk({name, " addr_err"}, 32'(addr_err), 32'd0);
  endtask

  initial begin
    logic found;
    logic allZero;
    int doneSeen;
    int busySeen;

    // r0v r0a r0d r0c | r1v r1a r1d r1c | eR0 eR1 eWr eClr eReg eData eErr
    vecs.push_back('{1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  32'h0,        1'b0});
    vecs.push_back('{1'b1, 4'd3,  32'hDEADBEEF, 1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3,  32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 4'd1,  32'h11,       1'b0, 1'b1, 4'd2,  32'h22,       1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2,  32'h22,       1'b0});
    vecs.push_back('{1'b1, 4'd1,  32'h11,       1'b0, 1'b1, 4'd2,  32'h22,       1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1,  32'h11,       1'b0});
    vecs.push_back('{1'b1, 4'd1,  32'h11,       1'b0, 1'b1, 4'd2,  32'h22,       1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2,  32'h22,       1'b0});
    vecs.push_back('{1'b1, 4'd1,  32'h11,       1'b0, 1'b1, 4'd2,  32'h22,       1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1,  32'h11,       1'b0});
    vecs.push_back('{1'b1, 4'd7,  32'h77,       1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7,  32'h77,       1'b0});
    vecs.push_back('{1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 4'd7,  32'h55,       1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd7,  32'h0,        1'b0});
    vecs.push_back('{1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7,  32'h0,        1'b0});
    vecs.push_back('{1'b1, 4'd15, 32'h1234,     1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7,  32'h0,        1'b1});
    vecs.push_back('{1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7,  32'h0,        1'b0});
    vecs.push_back('{1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 4'd14, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd14, 32'hA5A5A5A5, 1'b0});
    vecs.push_back('{1'b1, 4'd5,  32'h100,      1'b0, 1'b1, 4'd5,  32'h200,      1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd5,  32'h100,      1'b0});
    vecs.push_back('{1'b1, 4'd5,  32'h100,      1'b0, 1'b1, 4'd5,  32'h200,      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5,  32'h200,      1'b0});
    vecs.push_back('{1'b1, 4'd0,  32'hFFFF,     1'b1, 1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  32'h0,        1'b0});
    vecs.push_back('{1'b0, 4'd0,  32'h0,        1'b0, 1'b1, 4'd15, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  32'h0,        1'b1});
    vecs.push_back('{1'b1, 4'd12, 32'hC0FFEE,   1'b0, 1'b1, 4'd15, 32'h9,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd12, 32'hC0FFEE,   1'b0});
    vecs.push_back('{1'b1, 4'd12, 32'hC0FFEE,   1'b0, 1'b1, 4'd15, 32'h9,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd12, 32'hC0FFEE,   1'b1});

    for (int i = 0; i < 15; i++) tbRf[i] = 32'hBAD0_0000 + 32'(i);
    rst = 1'b0;
    r0_valid = 1'b0; r0_addr = '0; r0_data = '0; r0_clr = 1'b0;
    r1_valid = 1'b0; r1_addr = '0; r1_data = '0; r1_clr = 1'b0;
    sweep_start = 1'b0;
    #1;
    chkRfIdle("reset");
    #11 rst = 1'b1;
    cyc();

    for (int i = 0; i < vecs.size(); i++) begin
      r0_valid = vecs[i].r0v; r0_addr = vecs[i].r0a; r0_data = vecs[i].r0d; r0_clr = vecs[i].r0c;
      r1_valid = vecs[i].r1v; r1_addr = vecs[i].r1a; r1_data = vecs[i].r1d; r1_clr = vecs[i].r1c;
      #1;
      chk($sformatf("v%0d r0_ready", i), 32'(r0_ready), 32'(vecs[i].eR0));
      chk($sformatf("v%0d r1_ready", i), 32'(r1_ready), 32'(vecs[i].eR1));
      cyc();
      chk($sformatf("v%0d rf_reg_write", i), 32'(rf_reg_write), 32'(vecs[i].eWr));
      chk($sformatf("v%0d rf_sclr", i), 32'(rf_sclr), 32'(vecs[i].eClr));
      chk($sformatf("v%0d rf_write_reg", i), 32'(rf_write_reg), 32'(vecs[i].eReg));
      chk($sformatf("v%0d rf_write_data", i), rf_write_data, vecs[i].eData);
      chk($sformatf("v%0d addr_err", i), 32'(addr_err), 32'(vecs[i].eErr));
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("rf model reg7 cleared", tbRf[7], 32'd0);
    chk("rf model reg3 written", tbRf[3], 32'hDEADBEEF);

    // sweep while both requesters wait; last served was r1
    r0_valid = 1'b1; r0_addr = 4'd9;  r0_data = 32'h99;   r0_clr = 1'b0;
    r1_valid = 1'b1; r1_addr = 4'd10; r1_data = 32'h1010; r1_clr = 1'b0;
    sweep_start = 1'b1;
    #1;
    chk("sweep start r0_ready", 32'(r0_ready), 32'd0);
    chk("sweep start r1_ready", 32'(r1_ready), 32'd0);
    cyc();
    sweep_start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("sweep%0d rf_sclr", k), 32'(rf_sclr), 32'd1);
      chk($sformatf("sweep%0d rf_write_reg", k), 32'(rf_write_reg), 32'(k));
      chk($sformatf("sweep%0d rf_reg_write", k), 32'(rf_reg_write), 32'd0);
      chk($sformatf("sweep%0d busy", k), 32'(sweep_busy), 32'd1);
      chk($sformatf("sweep%0d done", k), 32'(sweep_done), 32'd0);
      chk($sformatf("sweep%0d readies", k), 32'({r1_ready, r0_ready}), 32'd0);
      if (k == 3) sweep_start = 1'b1;
      if (k == 4) sweep_start = 1'b0;
      cyc();
    end
    chk("sweep end rf_sclr", 32'(rf_sclr), 32'd0);
    chk("sweep end done", 32'(sweep_done), 32'd1);
    chk("sweep end busy", 32'(sweep_busy), 32'd0);
    chk("sweep end readies", 32'({r1_ready, r0_ready}), 32'd0);
    allZero = 1'b1;
    for (int i = 0; i < 15; i++) if (tbRf[i] !== 32'd0) allZero = 1'b0;
    chk("rf model all cleared", 32'(allZero), 32'd1);
    cyc();
    chk("post sweep done", 32'(sweep_done), 32'd0);
    chk("post sweep r0_ready", 32'(r0_ready), 32'd1);
    chk("post sweep r1_ready", 32'(r1_ready), 32'd0);
    cyc();
    r0_valid = 1'b0;
    chk("post sweep r0 write", 32'(rf_reg_write), 32'd1);
    chk("post sweep r0 reg", 32'(rf_write_reg), 32'd9);
    chk("post sweep r0 data", rf_write_data, 32'h99);
    #1;
    chk("post sweep r1_ready", 32'(r1_ready), 32'd1);
    cyc();
    r1_valid = 1'b0;
    chk("post sweep r1 reg", 32'(rf_write_reg), 32'd10);
    chk("post sweep r1 data", rf_write_data, 32'h1010);

    // reset in the middle of a sweep
    sweep_start = 1'b1;
    cyc();
    sweep_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (rf_sclr && rf_write_reg == 4'd6) found = 1'b1;
      else cyc();
    end
    chk("sweep reached index 6", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1;
    chkRfIdle("mid-sweep reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    doneSeen = 0;
    busySeen = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (sweep_done) doneSeen++;
      if (sweep_busy || rf_sclr) busySeen++;
    end
    chk("no done after reset", 32'(doneSeen), 32'd0);
    chk("no resumed sweep", 32'(busySeen), 32'd0);
    r0_valid = 1'b1; r0_addr = 4'd2; r0_data = 32'h22; r0_clr = 1'b0;
    #1;
    chk("after reset r0_ready", 32'(r0_ready), 32'd1);
    cyc();
    r0_valid = 1'b0;
    chk("after reset write", 32'(rf_reg_write), 32'd1);
    chk("after reset reg", 32'(rf_write_reg), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
